float_unpack_stage: RTL and testbench
=====================================

// Module: float_unpack_stage
// PURPOSE
//  Registered operand-unpack stage at the head of the FPU pipe.
//  - Splits a raw IEEE-754 binary32 operand into mantissa/exponent/sign and class flags.
//  - Resolves the dynamic rounding mode.
//  - Feeds ftoi_converter and the other FPU execution units over a valid/ready handshake.
//  - A 2-entry skid buffer keeps ready_out a registered signal.
// PARAMETERS
//  EXP_W  8   exponent width
//  MAN_W  23  stored fraction width; man_a is MAN_W+1 bits wide (hidden bit included)
// PORTS
//  clk          in   1        clock, rising edge
//  reset_n      in   1        asynchronous active-low reset
//  flush        in   1        synchronous pipeline flush
//  valid_in     in   1        upstream operand valid
//  ready_out    out  1        stage can accept (registered)
//  valid_out    out  1        unpacked operand valid
//  ready_in     in   1        downstream ready
//  op_in        in   5        FPU opcode (FPU_pkg encoding)
//  rm_in        in   3        instruction rounding mode
//  frm          in   3        CSR dynamic rounding mode
//  a            in   32       raw operand {sgn, exp, frac}
//  op           out  5        registered opcode
//  rm           out  3        resolved rounding mode
//  illegal_rm   out  1        resolved rm is 3'b101, 3'b110 or 3'b111
//  man_a        out  24       {hidden bit, fraction}
//  exp_a        out  8        biased exponent, subnormal mapped to 8'h01
//  sgn_a        out  1        sign
//  zero_a, inf_a, sNaN_a, qNaN_a, subnormal_a  out 1 each   class flags, mutually exclusive
// BEHAVIOUR
//  - Reset (reset_n=0, async): every output 0, ready_out=1, both entries empty.
//  - Accept: valid_in && ready_out. Unpacked result is registered; latency 1 cycle.
//  - Storage: output register (OUT) plus skid register (SKID).
//    - ready_out = !SKID.valid, registered.
//    - OUT is held stable while valid_out && !ready_in.
//  - Accept while OUT empty or draining, SKID empty: data -> OUT.
//  - Accept while OUT stalled: data -> SKID; ready_out falls in the next cycle.
//  - Drain (valid_out && ready_in) with SKID full: SKID -> OUT, SKID cleared, ready_out=1 next cycle.
//  - Drain and accept in the same cycle with SKID empty: new data -> OUT, valid_out stays 1.
//  - flush: clears OUT and SKID next cycle (valid_out=0, ready_out=1).
//    - Takes priority over accept and drain; the operand presented in a flush cycle is dropped.
//  - Reset mid-transfer: all contents discarded, no output pulse.
//  - rm resolution:
//    - rm = (rm_in==3'b111) ? frm : rm_in.
//    - illegal_rm = (rm >= 3'b101); rm is passed through unchanged.
//  - Classification, with e = a[30:23], f = a[22:0]:
//    - e==FF, f==0:        inf_a=1, man_a={1,f}, exp_a=FF.
//    - e==FF, f!=0, f[22]=1: qNaN_a=1.
//    - e==FF, f!=0, f[22]=0: sNaN_a=1.
//    - e==0, f==0:         zero_a=1, man_a=0, exp_a=0.
//    - e==0, f!=0:         subnormal_a=1, man_a={0,f}, exp_a=8'h01.
//    - otherwise (normal): man_a={1,f}, exp_a=e.
//  - sgn_a = a[31] in every class, including zero, NaN and DAZ-zero.
// CONFIGURATION
//  FPU_DAZ_EN defined: subnormal inputs are treated as zero.
//    - zero_a=1, subnormal_a=0, man_a=0, exp_a=0, sign kept.
//  FPU_DAZ_EN undefined: subnormals are unpacked as described above.
//    - subnormal_a is asserted for subnormal inputs.
// TESTING
//  1) a=32'h3FC00000, rm_in=000 -> 1 cycle later: man_a=24'hC00000, exp_a=8'h7F, all class flags 0.
//  2) a=32'h00000001 -> man_a=24'h000001, exp_a=8'h01, subnormal_a=1.
//     With FPU_DAZ_EN: zero_a=1, man_a=0, exp_a=0.
//  3) a=7F800001 -> sNaN_a=1; a=7FC00000 -> qNaN_a=1; a=FF800000 -> inf_a=1, sgn_a=1.
//  4) rm_in=111, frm=001 -> rm=001, illegal_rm=0; rm_in=111, frm=110 -> rm=110, illegal_rm=1.
//  5) ready_in=0, three back-to-back valid_in beats -> beat 1 in OUT, beat 2 in SKID,
//     ready_out=0, beat 3 not accepted. Release ready_in: beats delivered 1,2,3 in order, none lost.
//  6) flush while OUT and SKID are full -> next cycle valid_out=0, ready_out=1;
//     an operand presented in the flush cycle never appears at the output.

Source files
------------

// File: rtl/float_unpack_stage.sv
// Registered binary32 operand-unpack stage with a 2-entry (OUT + SKID) valid/ready buffer.
// Optional macro FPU_DAZ_EN: subnormal inputs are unpacked as signed zero.
module float_unpack_stage #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    input  logic [4:0]           op_in,
    input  logic [2:0]           rm_in,
    input  logic [2:0]           frm,
    input  logic [EXP_W+MAN_W:0] a,
    output logic [4:0]           op,
    output logic [2:0]           rm,
    output logic                 illegal_rm,
    output logic [MAN_W:0]       man_a,
    output logic [EXP_W-1:0]     exp_a,
    output logic                 sgn_a,
    output logic                 zero_a,
    output logic                 inf_a,
    output logic                 sNaN_a,
    output logic                 qNaN_a,
    output logic                 subnormal_a
);

    localparam int unsigned W = 1 + EXP_W + MAN_W;

    typedef struct packed {
        logic [4:0]       op;
        logic [2:0]       rm;
        logic             illegal_rm;
        logic [MAN_W:0]   man;
        logic [EXP_W-1:0] exp;
        logic             sgn;
        logic             zero;
        logic             inf;
        logic             snan;
        logic             qnan;
        logic             sub;
    } payload_t;

    payload_t         p_new;
    payload_t         out_q, out_d, skid_q, skid_d;
    logic             out_v_q, out_v_d, skid_v_q, skid_v_d, rdy_q, rdy_d;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    logic             accept, drain;

    // Decode the incoming operand and resolve the dynamic rounding mode.
    always_comb begin
        e     = a[W-2 -: EXP_W];
        f     = a[MAN_W-1:0];
        p_new = '0;
        p_new.op         = op_in;
        p_new.rm         = (rm_in == 3'b111) ? frm : rm_in;
        p_new.illegal_rm = (p_new.rm >= 3'b101);
        p_new.sgn        = a[W-1];
        if (e == {EXP_W{1'b1}}) begin
            p_new.exp = e;
            p_new.man = {1'b1, f};
            if (f == '0)
                p_new.inf = 1'b1;
            else if (f[MAN_W-1])
                p_new.qnan = 1'b1;
            else
                p_new.snan = 1'b1;
        end else if (e == '0) begin
            if (f == '0) begin
                p_new.zero = 1'b1;
            end else begin
`ifdef FPU_DAZ_EN
                p_new.zero = 1'b1;
`else
                p_new.sub = 1'b1;
                p_new.man = {1'b0, f};
                p_new.exp = EXP_W'(1);
`endif
            end
        end else begin
            p_new.exp = e;
            p_new.man = {1'b1, f};
        end
    end

    assign accept = valid_in && rdy_q;
    assign drain  = out_v_q && ready_in;

    // Buffer next-state: flush wins, then refill OUT from SKID or input, else park input in SKID.
    always_comb begin
        out_d    = out_q;
        out_v_d  = out_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            out_v_d  = 1'b0;
            skid_v_d = 1'b0;
        end else if (!out_v_q || drain) begin
            if (skid_v_q) begin
                out_d    = skid_q;
                out_v_d  = 1'b1;
                skid_v_d = 1'b0;
            end else if (accept) begin
                out_d   = p_new;
                out_v_d = 1'b1;
            end else begin
                out_v_d = 1'b0;
            end
        end else if (accept) begin
            skid_d   = p_new;
            skid_v_d = 1'b1;
        end
        rdy_d = !skid_v_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q    <= '0;
            skid_q   <= '0;
            out_v_q  <= 1'b0;
            skid_v_q <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            out_q    <= out_d;
            skid_q   <= skid_d;
            out_v_q  <= out_v_d;
            skid_v_q <= skid_v_d;
            rdy_q    <= rdy_d;
        end
    end

    assign ready_out   = rdy_q;
    assign valid_out   = out_v_q;
    assign op          = out_q.op;
    assign rm          = out_q.rm;
    assign illegal_rm  = out_q.illegal_rm;
    assign man_a       = out_q.man;
    assign exp_a       = out_q.exp;
    assign sgn_a       = out_q.sgn;
    assign zero_a      = out_q.zero;
    assign inf_a       = out_q.inf;
    assign sNaN_a      = out_q.snan;
    assign qNaN_a      = out_q.qnan;
    assign subnormal_a = out_q.sub;

endmodule

// File: tb/tb_float_unpack_stage.sv
// Directed bench for float_unpack_stage: classification, rounding-mode resolution,
// skid-buffer ordering under backpressure, flush and mid-transfer reset.
module tb_float_unpack_stage;

    logic        clk = 1'b0;
    logic        reset_n, flush, valid_in, ready_in;
    logic        ready_out, valid_out, illegal_rm, sgn_a;
    logic        zero_a, inf_a, sNaN_a, qNaN_a, subnormal_a;
    logic [4:0]  op_in, op;
    logic [2:0]  rm_in, frm, rm;
    logic [31:0] a;
    logic [23:0] man_a;
    logic [7:0]  exp_a;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    float_unpack_stage dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .valid_in(valid_in), .ready_out(ready_out),
        .valid_out(valid_out), .ready_in(ready_in),
        .op_in(op_in), .rm_in(rm_in), .frm(frm), .a(a),
        .op(op), .rm(rm), .illegal_rm(illegal_rm),
        .man_a(man_a), .exp_a(exp_a), .sgn_a(sgn_a),
        .zero_a(zero_a), .inf_a(inf_a), .sNaN_a(sNaN_a),
        .qNaN_a(qNaN_a), .subnormal_a(subnormal_a)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Flags ordered {zero, inf, sNaN, qNaN, subnormal}.
    task automatic send_and_check(input string tag, input logic [31:0] av, input logic [2:0] rmi,
                                  input logic [2:0] frmi, input logic [4:0] opi,
                                  input logic [23:0] x_man, input logic [7:0] x_exp,
                                  input logic [4:0] x_flags, input logic x_sgn,
                                  input logic [2:0] x_rm, input logic x_ill);
        @(negedge clk);
        a = av; rm_in = rmi; frm = frmi; op_in = opi; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        check({tag, "_valid"}, 32'(valid_out), 32'd1);
        check({tag, "_man"},   32'(man_a), 32'(x_man));
        check({tag, "_exp"},   32'(exp_a), 32'(x_exp));
        check({tag, "_flags"}, 32'({zero_a, inf_a, sNaN_a, qNaN_a, subnormal_a}), 32'(x_flags));
        check({tag, "_sgn"},   32'(sgn_a), 32'(x_sgn));
        check({tag, "_rm"},    32'({illegal_rm, rm}), 32'({x_ill, x_rm}));
        check({tag, "_op"},    32'(op), 32'(opi));
    endtask

    task automatic present(input logic [31:0] av);
        a = av; rm_in = 3'b000; frm = 3'b000; op_in = 5'd3; valid_in = 1'b1;
    endtask

    initial begin
        logic [23:0] exp_seq [3];
        int idx;
        logic acc;

        reset_n = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        op_in = '0; rm_in = '0; frm = '0; a = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_data", 32'({man_a, exp_a}), 32'd0);
        check("rst_flags", 32'({sgn_a, zero_a, inf_a, sNaN_a, qNaN_a, subnormal_a, illegal_rm, rm, op}), 32'd0);
        reset_n = 1'b1;

        send_and_check("norm", 32'h3FC00000, 3'b000, 3'b000, 5'd1, 24'hC00000, 8'h7F, 5'b00000, 1'b0, 3'b000, 1'b0);
`ifdef FPU_DAZ_EN
        send_and_check("sub",  32'h00000001, 3'b001, 3'b000, 5'd2, 24'h000000, 8'h00, 5'b10000, 1'b0, 3'b001, 1'b0);
        send_and_check("nsub", 32'h80400000, 3'b010, 3'b000, 5'd2, 24'h000000, 8'h00, 5'b10000, 1'b1, 3'b010, 1'b0);
`else
        send_and_check("sub",  32'h00000001, 3'b001, 3'b000, 5'd2, 24'h000001, 8'h01, 5'b00001, 1'b0, 3'b001, 1'b0);
        send_and_check("nsub", 32'h80400000, 3'b010, 3'b000, 5'd2, 24'h400000, 8'h01, 5'b00001, 1'b1, 3'b010, 1'b0);
`endif
        send_and_check("snan", 32'h7F800001, 3'b000, 3'b000, 5'd4, 24'h800001, 8'hFF, 5'b00100, 1'b0, 3'b000, 1'b0);
        send_and_check("qnan", 32'h7FC00000, 3'b000, 3'b000, 5'd5, 24'hC00000, 8'hFF, 5'b00010, 1'b0, 3'b000, 1'b0);
        send_and_check("ninf", 32'hFF800000, 3'b000, 3'b000, 5'd6, 24'h800000, 8'hFF, 5'b01000, 1'b1, 3'b000, 1'b0);
        send_and_check("nzero", 32'h80000000, 3'b000, 3'b000, 5'd7, 24'h000000, 8'h00, 5'b10000, 1'b1, 3'b000, 1'b0);
        send_and_check("norm2", 32'hC1234567, 3'b011, 3'b000, 5'd31, 24'hA34567, 8'h82, 5'b00000, 1'b1, 3'b011, 1'b0);
        send_and_check("dyn1", 32'h3F800000, 3'b111, 3'b001, 5'd8, 24'h800000, 8'h7F, 5'b00000, 1'b0, 3'b001, 1'b0);
        send_and_check("dyn6", 32'h3F800000, 3'b111, 3'b110, 5'd9, 24'h800000, 8'h7F, 5'b00000, 1'b0, 3'b110, 1'b1);
        send_and_check("rm5",  32'h3F800000, 3'b101, 3'b000, 5'd10, 24'h800000, 8'h7F, 5'b00000, 1'b0, 3'b101, 1'b1);
        send_and_check("rm4",  32'h3F800000, 3'b100, 3'b111, 5'd11, 24'h800000, 8'h7F, 5'b00000, 1'b0, 3'b100, 1'b0);

        // Back-to-back stream with ready_in=1: drain and accept in the same cycle.
        @(negedge clk);
        check("idle_valid", 32'(valid_out), 32'd0);
        present(32'h40100000);
        @(negedge clk);
        check("b2b1_man", 32'(man_a), 32'h900000);
        present(32'h40200000);
        @(negedge clk);
        valid_in = 1'b0;
        check("b2b2_valid", 32'(valid_out), 32'd1);
        check("b2b2_man", 32'(man_a), 32'hA00000);
        check("b2b2_ready", 32'(ready_out), 32'd1);
        @(negedge clk);
        check("b2b_empty", 32'(valid_out), 32'd0);

        // Backpressure: beat 1 -> OUT, beat 2 -> SKID, beat 3 held off.
        exp_seq[0] = 24'h880000; exp_seq[1] = 24'h900000; exp_seq[2] = 24'h980000;
        ready_in = 1'b0;
        present(32'h40080000);
        @(negedge clk);
        check("bp1_ready", 32'(ready_out), 32'd1);
        present(32'h40100000);
        @(negedge clk);
        check("bp2_ready", 32'(ready_out), 32'd0);
        check("bp2_man", 32'(man_a), 32'h880000);
        present(32'h40180000);
        @(negedge clk);
        check("bp3_ready", 32'(ready_out), 32'd0);
        check("bp3_man", 32'(man_a), 32'h880000);
        ready_in = 1'b1;
        idx = 0;
        acc = 1'b0;
        for (int c = 0; c < 10 && idx < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (acc) valid_in = 1'b0;
            if (valid_out) begin
                check($sformatf("bp_order%0d", idx), 32'(man_a), 32'(exp_seq[idx]));
                idx++;
            end
            acc = valid_in && ready_out;
        end
        check("bp_count", 32'(idx), 32'd3);
        @(negedge clk);
        valid_in = 1'b0;
        check("bp_done", 32'(valid_out), 32'd0);

        // Flush with both entries full; the flush-cycle operand is dropped.
        ready_in = 1'b0;
        present(32'h40400000);
        @(negedge clk);
        present(32'h40500000);
        @(negedge clk);
        check("fl_full", 32'(ready_out), 32'd0);
        present(32'h40600000);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        valid_in = 1'b0;
        check("fl_valid", 32'(valid_out), 32'd0);
        check("fl_ready", 32'(ready_out), 32'd1);
        ready_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("fl_quiet%0d", c), 32'(valid_out), 32'd0);
        end

        // Reset mid-transfer: stalled data discarded, no output pulse afterwards.
        ready_in = 1'b0;
        present(32'h40700000);
        @(negedge clk);
        present(32'h40780000);
        @(negedge clk);
        valid_in = 1'b0;
        check("mr_pre", 32'(valid_out), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mr_valid", 32'(valid_out), 32'd0);
        check("mr_ready", 32'(ready_out), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        ready_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("mr_quiet%0d", c), 32'(valid_out), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
